spi_xfer_ctrl: RTL and testbench

Transaction sequencer and configuration owner for the SPI byte engine. Accepts multi-byte transfer requests addressed to one of `NUM_SLAVES` slaves and drives active-low slave selects with programmed setup, hold and inter-byte gaps. Feeds the engine byte by byte from a TX stream, returns received bytes on an RX stream, and applies per-slave mode settings (cpol, cpha, dvsr) from an internal table.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_cfg_table.sv | 38 +++
 rtl/spi_xfer_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transaction controller and its
// per-slave configuration table.
package spi_pkg;

    localparam logic [15:0] DVSR_RST_DEFAULT = 16'd49;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    typedef struct packed {
        logic        cpol;
        logic        cpha;
        logic [15:0] dvsr;
    } cfg_entry_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_cfg_table.sv
// Per-slave SPI mode table: one write port, one combinational read port.
module spi_cfg_table
    import spi_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter int          SS_W       = 2,
    parameter logic [15:0] DVSR_RST   = DVSR_RST_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [SS_W-1:0] wr_slave,
    input  cfg_entry_t      wr_entry,
    input  logic [SS_W-1:0] rd_slave,
    output cfg_entry_t      rd_entry
);

    cfg_entry_t entries [NUM_SLAVES];

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_entry
            cfg_entry_t entry_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_reg <= '{cpol: 1'b0, cpha: 1'b0, dvsr: DVSR_RST};
                end else if (we && (wr_slave == SS_W'(gi))) begin
                    entry_reg <= wr_entry;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign rd_entry = entries[rd_slave];

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Multi-byte SPI transfer sequencer: slave-select timing, byte feeding to the
// engine, RX return and per-transfer snapshot of the slave's mode settings.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter int          SS_W       = 2,
    parameter int          CS_SETUP   = 4,
    parameter int          CS_HOLD    = 4,
    parameter int          BYTE_GAP   = 2,
    parameter logic [15:0] DVSR_RST   = DVSR_RST_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SS_W-1:0]       req_slave,
    input  logic [7:0]            req_len,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [7:0]            tx_data,
    output logic                  rx_valid,
    output logic [7:0]            rx_data,
    input  logic                  cfg_we,
    input  logic [SS_W-1:0]       cfg_slave,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic [15:0]           cfg_dvsr,
    output logic                  spi_start,
    output logic [7:0]            spi_din,
    output logic                  spi_cpol,
    output logic                  spi_cpha,
    output logic [15:0]           spi_dvsr,
    input  logic                  spi_ready,
    input  logic                  spi_done_tick,
    input  logic [7:0]            spi_dout,
    output logic [NUM_SLAVES-1:0] ss_n,
    output logic                  busy,
    output logic                  xfer_done_tick
);

    localparam int CNT_W = $clog2(max3(CS_SETUP, CS_HOLD, BYTE_GAP) + 1);

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [8:0]              remain_reg;
    cfg_entry_t              snap_reg;
    logic [NUM_SLAVES-1:0]   ss_n_reg;
    logic                    rx_valid_reg;
    logic [7:0]              rx_data_reg;
    logic                    done_tick_reg;
    logic                    req_ready_reg;
    cfg_entry_t              table_rd;
    logic                    accept;
    logic                    tx_fire;

    spi_cfg_table #(
        .NUM_SLAVES (NUM_SLAVES),
        .SS_W       (SS_W),
        .DVSR_RST   (DVSR_RST)
    ) u_cfg_table (
        .clk      (clk),
        .reset    (reset),
        .we       (cfg_we),
        .wr_slave (cfg_slave),
        .wr_entry ('{cpol: cfg_cpol, cpha: cfg_cpha, dvsr: cfg_dvsr}),
        .rd_slave (req_slave),
        .rd_entry (table_rd)
    );

    assign accept    = (state_reg == ST_IDLE) && req_ready_reg && req_valid;
    assign tx_ready  = (state_reg == ST_LOAD) && spi_ready;
    assign tx_fire   = tx_ready && tx_valid;
    assign spi_start = tx_fire;
    assign spi_din   = tx_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            remain_reg    <= '0;
            snap_reg      <= '{cpol: 1'b0, cpha: 1'b0, dvsr: DVSR_RST};
            ss_n_reg      <= '1;
            rx_valid_reg  <= 1'b0;
            rx_data_reg   <= '0;
            done_tick_reg <= 1'b0;
            req_ready_reg <= 1'b0;
        end else begin
            rx_valid_reg  <= 1'b0;
            done_tick_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    cnt_reg       <= '0;
                    if (accept) begin
                        req_ready_reg <= 1'b0;
                        remain_reg    <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
                        // Table read is combinational, so a same-cycle write is not yet visible.
                        snap_reg      <= table_rd;
                        ss_n_reg      <= ~(NUM_SLAVES'(1) << req_slave);
                        state_reg     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_reg == CNT_W'(CS_SETUP - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_LOAD;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (tx_fire) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (spi_done_tick) begin
                        rx_data_reg  <= spi_dout;
                        rx_valid_reg <= 1'b1;
                        remain_reg   <= remain_reg - 9'd1;
                        cnt_reg      <= '0;
                        if (remain_reg == 9'd1) begin
                            state_reg <= ST_HOLD;
                        end else if (BYTE_GAP == 0) begin
                            state_reg <= ST_LOAD;
                        end else begin
                            state_reg <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_reg == CNT_W'(BYTE_GAP - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_LOAD;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == CNT_W'(CS_HOLD - 1)) begin
                        cnt_reg       <= '0;
                        ss_n_reg      <= '1;
                        done_tick_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    ss_n_reg  <= '1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_reg;
    assign rx_valid       = rx_valid_reg;
    assign rx_data        = rx_data_reg;
    assign ss_n           = ss_n_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign xfer_done_tick = done_tick_reg;
    assign spi_cpol       = snap_reg.cpol;
    assign spi_cpha       = snap_reg.cpha;
    assign spi_dvsr       = snap_reg.dvsr;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a loopback byte-engine model
// (mosi->miso, fixed latency) and event logging for cycle-gap checks.
module tb_spi_xfer_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_ready;
    logic [1:0]  req_slave;
    logic [7:0]  req_len;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        cfg_we;
    logic [1:0]  cfg_slave;
    logic        cfg_cpol, cfg_cpha;
    logic [15:0] cfg_dvsr;
    logic        spi_start;
    logic [7:0]  spi_din;
    logic        spi_cpol, spi_cpha;
    logic [15:0] spi_dvsr;
    logic        spi_ready, spi_done_tick;
    logic [7:0]  spi_dout;
    logic [3:0]  ss_n;
    logic        busy, xfer_done_tick;

    always #5 clk = ~clk;

    spi_xfer_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_slave      (req_slave),
        .req_len        (req_len),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .cfg_we         (cfg_we),
        .cfg_slave      (cfg_slave),
        .cfg_cpol       (cfg_cpol),
        .cfg_cpha       (cfg_cpha),
        .cfg_dvsr       (cfg_dvsr),
        .spi_start      (spi_start),
        .spi_din        (spi_din),
        .spi_cpol       (spi_cpol),
        .spi_cpha       (spi_cpha),
        .spi_dvsr       (spi_dvsr),
        .spi_ready      (spi_ready),
        .spi_done_tick  (spi_done_tick),
        .spi_dout       (spi_dout),
        .ss_n           (ss_n),
        .busy           (busy),
        .xfer_done_tick (xfer_done_tick)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Loopback engine: 4 cycles from start to done, echoes the sent byte.
    logic [2:0] eng_cnt;
    logic [7:0] eng_data;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            spi_ready     <= 1'b1;
            spi_done_tick <= 1'b0;
            spi_dout      <= 8'h00;
            eng_cnt       <= 3'd0;
            eng_data      <= 8'h00;
        end else begin
            spi_done_tick <= 1'b0;
            if (spi_start) begin
                spi_ready <= 1'b0;
                eng_cnt   <= 3'd3;
                eng_data  <= spi_din;
            end else if (!spi_ready) begin
                if (eng_cnt == 3'd1) begin
                    spi_done_tick <= 1'b1;
                    spi_ready     <= 1'b1;
                    spi_dout      <= eng_data;
                end
                eng_cnt <= eng_cnt - 3'd1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled on the falling edge.
    int          accept_cyc[$], start_cyc[$], done_cyc[$], rise_cyc[$];
    logic [17:0] cfg_at_start[$];
    logic [7:0]  rx_q[$];
    int          xfer_cnt = 0;
    int          ss_bad = 0;
    int          ss_multi = 0;
    logic        ready_at_tick = 1'b1;
    logic [3:0]  exp_ss = 4'hF;
    logic [3:0]  prev_ss = 4'hF;

    always @(negedge clk) begin
        if (req_valid && req_ready) accept_cyc.push_back(cyc);
        if (spi_start) begin
            start_cyc.push_back(cyc);
            cfg_at_start.push_back({spi_cpol, spi_cpha, spi_dvsr});
        end
        if (spi_done_tick) done_cyc.push_back(cyc);
        if (rx_valid) rx_q.push_back(rx_data);
        if (xfer_done_tick) begin
            xfer_cnt++;
            ready_at_tick = req_ready;
        end
        if (ss_n == 4'hF && prev_ss != 4'hF) rise_cyc.push_back(cyc);
        if (busy && ss_n != exp_ss) ss_bad++;
        if ($countones(~ss_n) > 1) ss_multi++;
        prev_ss = ss_n;
    end

    // TX stream source: presents the head of tx_q, pops it after a handshake.
    logic [7:0] tx_q[$];
    logic       tx_fire_pend;
    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            tx_fire_pend = tx_valid && tx_ready;
            @(posedge clk);
            #1;
            if (tx_fire_pend && tx_q.size() > 0) void'(tx_q.pop_front());
            tx_valid = (tx_q.size() > 0);
            tx_data  = tx_valid ? tx_q[0] : 8'h00;
        end
    end

    task automatic clear_logs();
        accept_cyc.delete();
        start_cyc.delete();
        done_cyc.delete();
        rise_cyc.delete();
        cfg_at_start.delete();
        rx_q.delete();
        ss_bad = 0;
    endtask

    task automatic cfg_write(input logic [1:0] slave, input logic cpol, input logic cpha,
                             input logic [15:0] dvsr);
        @(negedge clk);
        cfg_we = 1'b1; cfg_slave = slave; cfg_cpol = cpol; cfg_cpha = cpha; cfg_dvsr = dvsr;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] slave, input logic [7:0] len);
        @(negedge clk);
        req_valid = 1'b1; req_slave = slave; req_len = len;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_xfer(input string tag, input int target, input int limit);
        for (int i = 0; i < limit && xfer_cnt < target; i++) @(negedge clk);
        chk(tag, 32'(xfer_cnt >= target), 32'd1);
        repeat (3) @(negedge clk);
        $display("xfer %s: starts=%0d rx=%0d done_total=%0d", tag, start_cyc.size(),
                 rx_q.size(), xfer_cnt);
    endtask

    initial begin
        int base;
        int bad;
        req_valid = 1'b0; req_slave = 2'd0; req_len = 8'd0;
        cfg_we = 1'b0; cfg_slave = 2'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_dvsr = 16'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss_n", 32'(ss_n), 32'hF);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_done_tick", 32'(xfer_done_tick), 32'd0);
        chk("rst_snapshot", 32'({spi_cpol, spi_cpha, spi_dvsr}), 32'd49);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ss_n", 32'(ss_n), 32'hF);

        // Slave 2, mode {1,1,3}, three bytes with timing gaps
        cfg_write(2'd2, 1'b1, 1'b1, 16'd3);
        clear_logs();
        exp_ss = 4'b1011;
        tx_q.push_back(8'hA5); tx_q.push_back(8'h3C); tx_q.push_back(8'hFF);
        repeat (2) @(negedge clk);
        do_req(2'd2, 8'd3);
        wait_xfer("xfer3_timeout", 1, 500);
        chk("xfer3_starts", 32'(start_cyc.size()), 32'd3);
        chk("xfer3_rx_cnt", 32'(rx_q.size()), 32'd3);
        chk("xfer3_rx0", 32'(rx_q[0]), 32'hA5);
        chk("xfer3_rx1", 32'(rx_q[1]), 32'h3C);
        chk("xfer3_rx2", 32'(rx_q[2]), 32'hFF);
        chk("xfer3_ss_bad", 32'(ss_bad), 32'd0);
        chk("xfer3_cfg", 32'(cfg_at_start[0]), 32'h30003);
        chk("gap_accept_start", 32'(start_cyc[0] - accept_cyc[0]), 32'd5);
        chk("gap_done_start", 32'(start_cyc[1] - done_cyc[0]), 32'd3);
        chk("gap_done_rise", 32'(rise_cyc[0] - done_cyc[2]), 32'd5);
        chk("ready_at_tick", 32'(ready_at_tick), 32'd0);
        chk("ready_after_tick", 32'(req_ready), 32'd1);

        // len=0 means 256 bytes, slave 0 default mode
        clear_logs();
        exp_ss = 4'b1110;
        base = xfer_cnt;
        for (int k = 0; k < 256; k++) tx_q.push_back(8'(k));
        do_req(2'd0, 8'd0);
        wait_xfer("len0_timeout", base + 1, 5000);
        repeat (10) @(negedge clk);
        chk("len0_starts", 32'(start_cyc.size()), 32'd256);
        chk("len0_rx_cnt", 32'(rx_q.size()), 32'd256);
        bad = 0;
        for (int k = 0; k < rx_q.size(); k++) if (rx_q[k] != 8'(k)) bad++;
        chk("len0_rx_bad", 32'(bad), 32'd0);
        chk("len0_done_cnt", 32'(xfer_cnt - base), 32'd1);
        chk("len0_cfg", 32'(cfg_at_start[0]), 32'd49);
        chk("len0_ss_bad", 32'(ss_bad), 32'd0);

        // TX underflow stall in LOAD
        clear_logs();
        exp_ss = 4'b0111;
        base = xfer_cnt;
        do_req(2'd3, 8'd2);
        repeat (25) @(negedge clk);
        chk("stall_starts", 32'(start_cyc.size()), 32'd0);
        chk("stall_ss_n", 32'(ss_n), 32'b0111);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_tx_ready", 32'(tx_ready), 32'd1);
        tx_q.push_back(8'h11); tx_q.push_back(8'h22);
        wait_xfer("stall_timeout", base + 1, 500);
        chk("stall_rx0", 32'(rx_q[0]), 32'h11);
        chk("stall_rx1", 32'(rx_q[1]), 32'h22);
        chk("stall_ss_bad", 32'(ss_bad), 32'd0);

        // Config writes on accept cycle and mid-transfer must not affect slave 1
        clear_logs();
        exp_ss = 4'b1101;
        base = xfer_cnt;
        tx_q.push_back(8'h5A); tx_q.push_back(8'hC3);
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_slave = 2'd1; req_len = 8'd2;
        cfg_we = 1'b1; cfg_slave = 2'd1; cfg_cpol = 1'b0; cfg_cpha = 1'b1; cfg_dvsr = 16'd7;
        @(posedge clk);
        #1 req_valid = 1'b0; cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        cfg_write(2'd1, 1'b0, 1'b1, 16'd9);
        wait_xfer("cfgmid_timeout", base + 1, 500);
        chk("cfgmid_accept", 32'(accept_cyc.size()), 32'd1);
        chk("cfgmid_cfg0", 32'(cfg_at_start[0]), 32'd49);
        chk("cfgmid_cfg1", 32'(cfg_at_start[1]), 32'd49);
        chk("cfgmid_idle_dvsr", 32'(spi_dvsr), 32'd49);
        clear_logs();
        tx_q.push_back(8'h77);
        do_req(2'd1, 8'd1);
        wait_xfer("cfgnext_timeout", base + 2, 500);
        chk("cfgnext_cfg", 32'(cfg_at_start[0]), 32'h10009);
        chk("cfgnext_rx", 32'(rx_q[0]), 32'h77);

        // Asynchronous reset in the middle of WAIT
        clear_logs();
        exp_ss = 4'b1011;
        tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03);
        do_req(2'd2, 8'd3);
        for (int i = 0; i < 100 && start_cyc.size() == 0; i++) @(negedge clk);
        chk("rstmid_started", 32'(start_cyc.size()), 32'd1);
        @(negedge clk);
        base = xfer_cnt;
        #2 reset = 1'b0;
        #1;
        chk("rstmid_ss_n", 32'(ss_n), 32'hF);
        chk("rstmid_busy", 32'(busy), 32'd0);
        tx_q.delete();
        @(negedge clk) reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("rstmid_no_done", 32'(xfer_cnt - base), 32'd0);
        chk("rstmid_ss_after", 32'(ss_n), 32'hF);
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        chk("rstmid_snapshot", 32'({spi_cpol, spi_cpha, spi_dvsr}), 32'd49);

        chk("ss_one_hot", 32'(ss_multi), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
